uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_RATE, default 100000000, clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 250000, line bit rate.
REQ-003 Parameter N_BITS, default 8, data bits per frame, legal 5..9.
REQ-004 Parameter N_SAMPLES, default 16, oversample ticks per bit, legal 8..32, even.
REQ-005 Parameter PARITY, default PAR_NONE, one of PAR_NONE/PAR_EVEN/PAR_ODD.
REQ-006 Parameter N_STOP, default 1, stop bits, legal 1 or 2.
REQ-007 clk  input  1  single clock; all logic on posedge clk.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-010 data  output  N_BITS  received word, LSB received first.
REQ-011 valid  output  1  data and error flags are held and valid.
REQ-012 ready  input  1  consumer accepts; transfer when valid && ready.
REQ-013 parity_err  output  1  parity mismatch for the held word; 0 when PARITY=PAR_NONE.
REQ-014 framing_err  output  1  any stop bit sampled low for the held word.
REQ-015 break_det  output  1  held word is all zero with framing_err set.
REQ-016 overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-017 rx SHALL pass through a 2-flop synchroniser; all logic uses the synchronised rx_s.
REQ-018 Tick divider DIV = CLOCK_RATE/(BAUD_RATE*N_SAMPLES), integer-truncated, elaboration error if DIV < 2; one-clk tick every DIV clocks.
REQ-019 States IDLE, START, DATA, PARITY, STOP, from uart_pkg.
REQ-020 IDLE: a 1->0 transition of rx_s restarts the divider and tick count at 0 and enters START.
REQ-021 Every bit is majority-voted from rx_s at ticks N_SAMPLES/2-1, N_SAMPLES/2 and N_SAMPLES/2+1; the vote is final at tick N_SAMPLES/2+1.
REQ-022 START: vote 1 -> false start, return to IDLE with no output; vote 0 -> after tick N_SAMPLES-1, enter DATA.
REQ-023 DATA: shift N_BITS votes LSB-first; after the last bit, enter PARITY if PARITY != PAR_NONE, else STOP.
REQ-024 PARITY: the error is set when XOR(data bits, parity vote) is 1 for PAR_EVEN or 0 for PAR_ODD.
REQ-025 STOP: vote each of N_STOP bits; framing error if any vote is 0.
REQ-026 The frame completes at the final stop bit's vote tick; the FSM returns to IDLE on the next clk, mid-stop-bit, to resynchronise early.
REQ-027 On completion with valid=0, or with valid=1 and ready=1 in the same cycle, load data/flags and set valid=1 on the next clk.
REQ-028 On completion with valid=1 and ready=0, drop the new frame, keep the held word unchanged and pulse overrun for 1 clk.
REQ-029 valid SHALL clear on the clk after valid && ready unless a reload per REQ-027 occurs.
REQ-030 data and flags SHALL remain stable while valid=1 && ready=0.
REQ-031 In IDLE, a falling edge is not recognised while rx_s stays low after a break; rx_s must return high first.

Reset
REQ-032 With rst_n low: state=IDLE, divider/tick/bit counters=0, synchroniser flops=1, data=0, valid=0, all error outputs=0, overrun=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no output; reception resumes on the first falling edge after deassertion.

Structure
REQ-034 uart_pkg SHALL hold the state_t enum, the parity_t enum (PAR_NONE/PAR_EVEN/PAR_ODD) and the legal-range constants.
REQ-035 The tick generator SHALL be a sub-module uart_baud_tick (clk, rst_n, restart, tick), parameterised by DIV.

Verification (defaults unless noted: DIV=25, bit period 400 clk)
REQ-036 8N1 frame 0xA5, ready=1 -> data=0xA5, valid high 1 clk, all flags 0, valid rises within 1 clk of stop-bit tick 9.
REQ-037 PARITY=PAR_EVEN, 0x07 sent with parity bit 0 -> data=0x07, parity_err=1; resend with parity bit 1 -> parity_err=0.
REQ-038 Low glitch of 100 clk on idle rx -> no valid, FSM back in IDLE; the next frame 0x3C is received correctly.
REQ-039 Frame with stop bit 0 -> framing_err=1; all-zero frame with low stop -> break_det=1; no new frame until rx returns high.
REQ-040 Two back-to-back frames 0x11, 0x22, ready=0 -> data stays 0x11, overrun pulses once; on ready=1, valid clears next clk.
REQ-041 rst_n pulsed low during bit 4 of a frame -> outputs at reset values, no valid; the following frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and legal parameter ranges for the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    localparam int unsigned N_BITS_MIN    = 5;
    localparam int unsigned N_BITS_MAX    = 9;
    localparam int unsigned N_SAMPLES_MIN = 8;
    localparam int unsigned N_SAMPLES_MAX = 32;
    localparam int unsigned N_STOP_MIN    = 1;
    localparam int unsigned N_STOP_MAX    = 2;
    localparam int unsigned DIV_MIN       = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clocks, realignable by restart.
module uart_baud_tick #(
    parameter int unsigned DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (restart) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with majority-vote sampling, optional parity,
// framing/break detection and a single-entry valid/ready output holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 100000000,
    parameter int unsigned BAUD_RATE  = 250000,
    parameter int unsigned N_BITS     = 8,
    parameter int unsigned N_SAMPLES  = 16,
    parameter parity_t     PARITY     = PAR_NONE,
    parameter int unsigned N_STOP     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [N_BITS-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              parity_err,
    output logic              framing_err,
    output logic              break_det,
    output logic              overrun
);
    localparam int unsigned DIV = CLOCK_RATE / (BAUD_RATE * N_SAMPLES);
    localparam int unsigned TW  = $clog2(N_SAMPLES);
    localparam int unsigned BW  = $clog2(N_BITS);

    localparam logic [TW-1:0] T_S0   = TW'(N_SAMPLES / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(N_SAMPLES / 2);
    localparam logic [TW-1:0] T_VOTE = TW'(N_SAMPLES / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(N_SAMPLES - 1);

    if (DIV < DIV_MIN) begin : g_div_chk
        $error("uart_rx: clock too slow for BAUD_RATE*N_SAMPLES");
    end
    if (N_BITS < N_BITS_MIN || N_BITS > N_BITS_MAX) begin : g_bits_chk
        $error("uart_rx: N_BITS out of range");
    end
    if (N_SAMPLES < N_SAMPLES_MIN || N_SAMPLES > N_SAMPLES_MAX || (N_SAMPLES % 2) != 0) begin : g_smp_chk
        $error("uart_rx: N_SAMPLES out of range or odd");
    end
    if (N_STOP < N_STOP_MIN || N_STOP > N_STOP_MAX) begin : g_stop_chk
        $error("uart_rx: N_STOP out of range");
    end

    logic              rx_meta, rx_s, rx_q;
    state_t            state_q, state_d;
    logic              tick;
    logic [TW-1:0]     tick_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              stop_cnt;
    logic [1:0]        smp;
    logic [N_BITS-1:0] shreg;
    logic              par_bit;
    logic              ferr_acc;

    logic vote_c, vote_tick_c, end_tick_c;
    logic restart_c, shift_c, par_cap_c, stop_chk_c, done_c, bit_inc_c, stop_inc_c;
    logic par_err_c, frm_err_c;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart_c),
        .tick    (tick)
    );

    // Two-flop synchroniser plus one delay stage for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    assign vote_c      = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    assign vote_tick_c = tick && (tick_cnt == T_VOTE);
    assign end_tick_c  = tick && (tick_cnt == T_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        restart_c  = 1'b0;
        shift_c    = 1'b0;
        par_cap_c  = 1'b0;
        stop_chk_c = 1'b0;
        done_c     = 1'b0;
        bit_inc_c  = 1'b0;
        stop_inc_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_q && !rx_s) begin
                    restart_c = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (vote_tick_c && vote_c) state_d = ST_IDLE;
                else if (end_tick_c)       state_d = ST_DATA;
            end
            ST_DATA: begin
                shift_c = vote_tick_c;
                if (end_tick_c) begin
                    if (bit_cnt == BW'(N_BITS - 1))
                        state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    else
                        bit_inc_c = 1'b1;
                end
            end
            ST_PARITY: begin
                par_cap_c = vote_tick_c;
                if (end_tick_c) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Complete at the last stop bit's vote so the next start edge is seen early.
                if (vote_tick_c) begin
                    stop_chk_c = 1'b1;
                    if (stop_cnt == 1'(N_STOP - 1)) begin
                        done_c  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (end_tick_c) begin
                    stop_inc_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            smp      <= 2'b11;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            ferr_acc <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            if (restart_c)                       tick_cnt <= '0;
            else if (tick && tick_cnt == T_LAST) tick_cnt <= '0;
            else if (tick)                       tick_cnt <= tick_cnt + TW'(1);

            if (tick && tick_cnt == T_S0) smp[0] <= rx_s;
            if (tick && tick_cnt == T_S1) smp[1] <= rx_s;

            if (restart_c) begin
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                ferr_acc <= 1'b0;
            end else begin
                if (bit_inc_c)              bit_cnt  <= bit_cnt + BW'(1);
                if (stop_inc_c)             stop_cnt <= 1'b1;
                if (stop_chk_c && !vote_c)  ferr_acc <= 1'b1;
            end

            if (shift_c)   shreg   <= {vote_c, shreg[N_BITS-1:1]};
            if (par_cap_c) par_bit <= vote_c;
        end
    end

    always_comb begin
        par_err_c = 1'b0;
        if (PARITY == PAR_EVEN)     par_err_c = ^shreg ^ par_bit;
        else if (PARITY == PAR_ODD) par_err_c = ~(^shreg ^ par_bit);
        frm_err_c = ferr_acc | ~vote_c;
    end

    // Output holding register: load when empty or draining, otherwise drop and flag overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data        <= '0;
            valid       <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            break_det   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done_c) begin
                if (!valid || ready) begin
                    valid       <= 1'b1;
                    data        <= shreg;
                    parity_err  <= par_err_c;
                    framing_err <= frm_err_c;
                    break_det   <= frm_err_c && (shreg == '0);
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
